// File: rtl/fmadd_mul_pn_pkg.sv
// Shared constants and state encoding for the FMADD multiply/pre-normalise stage.
// Default field geometry is single precision.
package fmadd_mul_pn_pkg;

    localparam int STD_D  = 31;
    localparam int MAN_D  = 22;
    localparam int EXP_D  = 7;
    localparam int BIAD_D = 127;

    localparam int SIG_W  = MAN_D + 2;
    localparam int PROD_W = 2 * MAN_D + 4;
    localparam int EXP_W  = EXP_D + 1;
    localparam int NO_W   = 2 * MAN_D + EXP_D + 6;

    // Layout of the wide unrounded word handed to the rounder
    localparam int SIGN_POS = 2 * MAN_D + EXP_D + 5;
    localparam int EXP_HI   = 2 * MAN_D + EXP_D + 4;
    localparam int EXP_LO   = 2 * MAN_D + 4;
    localparam int PROD_HI  = 2 * MAN_D + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fmadd_mul_pn_if.sv
// Operand/result handshake bundle between the operand source, this stage and the rounder.
interface fmadd_mul_pn_if
    import fmadd_mul_pn_pkg::*;
#(
    parameter int STD = STD_D,
    parameter int MAN = MAN_D,
    parameter int EXP = EXP_D
);
    logic                     in_valid;
    logic                     in_ready;
    logic [STD:0]             in_a;
    logic [STD:0]             in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*MAN+EXP+5:0]     out_no;
    logic                     out_overflow;
    logic                     out_sticky_pn;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_no, out_overflow, out_sticky_pn
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_no, out_overflow, out_sticky_pn
    );
endinterface

// File: rtl/fmadd_mul_pn_core.sv
// Iterative shift-add significand multiplier: one multiplier bit per cycle, LSB first,
// done pulses for one cycle after the last partial product has been accumulated.
module fmadd_mul_pn_core #(
    parameter int MAN = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MAN+1:0]       mcand,
    input  logic [MAN+1:0]       mplier,
    output logic [2*MAN+3:0]     acc,
    output logic                 done
);
    localparam int SIGW  = MAN + 2;
    localparam int PRODW = 2 * MAN + 4;
    localparam int CNTW  = $clog2(SIGW);
    localparam logic [CNTW-1:0] LAST = CNTW'(MAN + 1);

    logic [PRODW-1:0] acc_p0;
    logic [PRODW-1:0] mcand_sh_p0;
    logic [SIGW-1:0]  mplier_p0;
    logic [CNTW-1:0]  cnt;
    logic             busy;
    logic             vld_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0      <= '0;
            mcand_sh_p0 <= '0;
            mplier_p0   <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            vld_p0      <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (start) begin
                acc_p0      <= '0;
                mcand_sh_p0 <= PRODW'(mcand);
                mplier_p0   <= mplier;
                cnt         <= '0;
                busy        <= 1'b1;
            end else if (busy) begin
                // mcand_sh_p0 always equals mcand << cnt here
                if (mplier_p0[cnt])
                    acc_p0 <= acc_p0 + mcand_sh_p0;
                mcand_sh_p0 <= mcand_sh_p0 << 1;
                cnt         <= cnt + 1'b1;
                if (cnt == LAST) begin
                    busy   <= 1'b0;
                    vld_p0 <= 1'b1;
                end
            end
        end
    end

    assign acc  = acc_p0;
    assign done = vld_p0;

endmodule

// File: rtl/fmadd_mul_pn.sv
// FMADD multiply/pre-normalise stage: exact significand product, 1-bit normalisation,
// biased exponent with overflow/flush, and sticky of the bit shifted out.
module fmadd_mul_pn
    import fmadd_mul_pn_pkg::*;
#(
    parameter int STD  = STD_D,
    parameter int MAN  = MAN_D,
    parameter int EXP  = EXP_D,
    parameter int BIAD = BIAD_D
) (
    input  logic          clk,
    input  logic          rst,
    fmadd_mul_pn_if.slave bus
);
    localparam int SIGW  = MAN + 2;
    localparam int PRODW = 2 * MAN + 4;
    localparam int EW    = EXP + 1;
    localparam int SUMW  = EXP + 3;
    localparam int NOW   = PRODW + EW + 1;

    localparam logic signed [SUMW-1:0] BIAD_S  = SUMW'(BIAD);
    localparam logic signed [SUMW-1:0] ONE_S   = SUMW'(1);
    localparam logic signed [SUMW-1:0] ZERO_S  = '0;
    localparam logic signed [SUMW-1:0] OVF_LIM = SUMW'((1 << EW) - 1);

    // Returns {overflow, sticky, sign, exponent, product}. The raw product of two
    // normal significands has its leading one at bit PRODW-1 or PRODW-2; both cases
    // end with the leading one at the top of the product field.
    function automatic logic [NOW+1:0] norm_pack(
        input logic                   sign,
        input logic signed [SUMW-1:0] sum,
        input logic                   zero,
        input logic [PRODW-1:0]       p
    );
        logic                   shift;
        logic signed [SUMW-1:0] e;
        logic [PRODW-1:0]       q;
        logic                   st;
        shift = p[PRODW-1];
        e     = sum + (shift ? ONE_S : ZERO_S);
        q     = shift ? {p[PRODW-1:1], 1'b0} : {p[PRODW-2:0], 1'b0};
        st    = shift & p[0];
        if (zero || e <= ZERO_S)
            norm_pack = {1'b0, 1'b0, sign, {EW{1'b0}}, {PRODW{1'b0}}};
        else if (e >= OVF_LIM)
            norm_pack = {1'b1, 1'b0, sign, {EW{1'b1}}, {PRODW{1'b0}}};
        else
            norm_pack = {1'b0, st, sign, e[EW-1:0], q};
    endfunction

    state_t state, state_nxt;

    logic [EW-1:0]          ea, eb;
    logic [SIGW-1:0]        sig_a, sig_b;
    logic signed [SUMW-1:0] sum_in;
    logic                   accept;

    logic                   sign_p0;
    logic signed [SUMW-1:0] sum_p0;
    logic                   zero_p0;

    logic [PRODW-1:0]       prod;
    logic                   core_done;
    logic [NOW+1:0]         norm_w;

    logic [NOW-1:0]         no_p1;
    logic                   ovf_p1;
    logic                   sticky_p1;

    assign ea     = bus.in_a[MAN+1 +: EW];
    assign eb     = bus.in_b[MAN+1 +: EW];
    assign sig_a  = {|ea, bus.in_a[MAN:0]};
    assign sig_b  = {|eb, bus.in_b[MAN:0]};
    assign sum_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAD_S;
    assign accept = (state == IDLE) && bus.in_valid;

    fmadd_mul_pn_core #(.MAN(MAN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (accept),
        .mcand  (sig_a),
        .mplier (sig_b),
        .acc    (prod),
        .done   (core_done)
    );

    assign norm_w = norm_pack(sign_p0, sum_p0, zero_p0, prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sign_p0   <= 1'b0;
            sum_p0    <= '0;
            zero_p0   <= 1'b0;
            no_p1     <= '0;
            ovf_p1    <= 1'b0;
            sticky_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            // operand capture -> multiply
            if (accept) begin
                sign_p0 <= bus.in_a[STD] ^ bus.in_b[STD];
                sum_p0  <= sum_in;
                zero_p0 <= ~|sig_a | ~|sig_b;
            end
            // normalise -> result hold
            if (state == NORM) begin
                no_p1     <= norm_w[NOW-1:0];
                ovf_p1    <= norm_w[NOW+1];
                sticky_p1 <= norm_w[NOW];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = MUL;
            end
            MUL:  if (core_done) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.out_no        = no_p1;
    assign bus.out_overflow  = ovf_p1;
    assign bus.out_sticky_pn = sticky_p1;

endmodule

// File: tb/tb_fmadd_mul_pn.sv
// Scoreboard bench for fmadd_mul_pn: arithmetic reference model, directed corner cases,
// randomized operands, backpressure and mid-operation reset.
module tb_fmadd_mul_pn;
    import fmadd_mul_pn_pkg::*;

    typedef struct {
        logic [NO_W-1:0] no;
        logic            ovf;
        logic            st;
        int              t;
    } exp_t;

    localparam int LAT = MAN_D + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    bit   prev_vld = 1'b0;

    fmadd_mul_pn_if bus ();

    fmadd_mul_pn dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Real-valued rules: significand = hidden*2^23 + mantissa, product normalised so
    // its leading one sits at bit 47 of the product field.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        longint unsigned sa, sb, p, frac;
        int ea, eb, e;
        logic sg, st;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = (ea != 0 ? 64'h800000 : 64'd0) + 64'(a[22:0]);
        sb = (eb != 0 ? 64'h800000 : 64'd0) + 64'(b[22:0]);
        sg = a[31] ^ b[31];
        e  = ea + eb - 127;
        p  = sa * sb;
        if (p >= (64'd1 << 47)) begin
            e    = e + 1;
            st   = p[0];
            frac = p - (p % 2);
        end else begin
            st   = 1'b0;
            frac = p * 2;
        end
        r.t = 0;
        if (sa == 0 || sb == 0 || e <= 0) begin
            r.no = {sg, 8'd0, 48'd0}; r.ovf = 1'b0; r.st = 1'b0;
        end else if (e >= 255) begin
            r.no = {sg, 8'hFF, 48'd0}; r.ovf = 1'b1; r.st = 1'b0;
        end else begin
            r.no = {sg, 8'(e), frac[47:0]}; r.ovf = 1'b0; r.st = st;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 255));
        else                            e = 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e = model(a, b);
        e.t = cyc;
        sb_q.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending=%0d required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: compares every presented result against the head of the scoreboard,
    // so held results are re-checked on each cycle of backpressure.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %h required no output", bus.out_no);
            end else begin
                if (!prev_vld) chk("latency", 64'(cyc - sb_q[0].t), 64'(LAT));
                chk("out_no", 64'(bus.out_no), 64'(sb_q[0].no));
                chk("out_overflow", 64'(bus.out_overflow), 64'(sb_q[0].ovf));
                chk("out_sticky_pn", 64'(bus.out_sticky_pn), 64'(sb_q[0].st));
                if (bus.out_ready) void'(sb_q.pop_front());
            end
        end
        prev_vld = bus.out_valid;
    end

    logic [31:0] ra, rb;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_no", 64'(bus.out_no), 64'd0);
        chk("rst_overflow", 64'(bus.out_overflow), 64'd0);
        chk("rst_sticky", 64'(bus.out_sticky_pn), 64'd0);
        rst = 1'b0;

        issue(32'h3F800000, 32'h3F800000);
        issue(32'h3FC00000, 32'h3FC00000);
        issue(32'h3FFFFFFF, 32'h3FFFFFFF);
        issue(32'h7F000000, 32'h7F000000);
        issue(32'h00800000, 32'h00800000);
        issue(32'h00000000, 32'h40490FDB);
        issue(32'hBF800000, 32'h40000000);
        issue(32'h7F7FFFFF, 32'h3F800000);
        drain();

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            issue(ra, rb);
        end
        drain();

        // Backpressure: result must hold while out_ready is low; new operands ignored
        bus.out_ready = 1'b0;
        issue(32'h40000000, 32'h40400000);
        for (int n = 0; n < 100 && !bus.out_valid; n++) @(negedge clk);
        chk("bp_reach_done", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            if (i == 3) begin
                bus.in_a = 32'h3F800000;
                bus.in_b = 32'h40000000;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (40) @(negedge clk);

        // Reset during the multiply phase
        issue(32'h3F800000, 32'h3F800000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_out_no", 64'(bus.out_no), 64'd0);
        chk("abort_overflow", 64'(bus.out_overflow), 64'd0);
        chk("abort_sticky", 64'(bus.out_sticky_pn), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'h3F800000, 32'h3F800000);
        drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
